mem_loader: RTL and testbench



---
 rtl/mem_loader.sv | 217 +++++++++++++++++++++
 tb/tb_mem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Host-to-memory loader: streams an instruction and a data image into two
// external memories, reads both back, compares checksums and then enables the CPU.
module mem_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [9:0]  imem_len,
  input  logic [10:0] dmem_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 12;

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RB_I, RB_D, CHECK, RUN, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] ilen_q, ilen_d, dlen_q, dlen_d;
  logic [DW-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
  logic          rd_pend_q, rd_pend_d, rd_sel_q, rd_sel_d;
  logic          oversize, beat;

  logic          s_ready_d, cpu_enable_d, busy_d, done_d, error_d;
  logic          wen_i_d, ren_i_d, wen_d_d, ren_d_d;
  logic [AW-1:0] addr_i_d, addr_d_d;
  logic [DW-1:0] wdata_i_d, wdata_d_d;
  logic [AW-1:0] cnt_addr;

  assign cnt_inc  = cnt_q + CW'(1);
  assign cnt_addr = AW'({cnt_q, 2'b00});
  assign beat     = s_valid & s_ready;
  assign oversize = (LW'(imem_len) > LW'(IMEM_WORDS)) || (LW'(dmem_len) > LW'(DMEM_WORDS));

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ilen_d    = ilen_q;
    dlen_d    = dlen_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    rd_pend_d = ren_ext | ren_ext_2;
    rd_sel_d  = ren_ext_2;
    done_d    = 1'b0;
    wen_i_d   = 1'b0;
    ren_i_d   = 1'b0;
    wen_d_d   = 1'b0;
    ren_d_d   = 1'b0;
    addr_i_d  = '0;
    addr_d_d  = '0;
    wdata_i_d = '0;
    wdata_d_d = '0;

    // Read data arrives one cycle after the registered read enable
    if (rd_pend_q) rsum_d = rsum_q + (rd_sel_q ? rdata_ext_2 : rdata_ext);

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          ilen_d = CW'(imem_len);
          dlen_d = dmem_len;
          cnt_d  = '0;
          wsum_d = '0;
          rsum_d = '0;
          if (oversize)            state_d = ERR;
          else if (imem_len != '0) state_d = LOAD_I;
          else if (dmem_len != '0) state_d = LOAD_D;
          else                     state_d = CHECK;
        end
      end
      LOAD_I: begin
        if (beat) begin
          wen_i_d   = 1'b1;
          addr_i_d  = cnt_addr;
          wdata_i_d = s_data;
          wsum_d    = wsum_q + s_data;
          if (cnt_inc == ilen_q) begin
            cnt_d   = '0;
            state_d = (dlen_q != '0) ? LOAD_D : RB_I;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LOAD_D: begin
        if (beat) begin
          wen_d_d   = 1'b1;
          addr_d_d  = cnt_addr;
          wdata_d_d = s_data;
          wsum_d    = wsum_q + s_data;
          if (cnt_inc == dlen_q) begin
            cnt_d   = '0;
            state_d = (ilen_q != '0) ? RB_I : RB_D;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RB_I: begin
        if (cnt_q != ilen_q) begin
          ren_i_d  = 1'b1;
          addr_i_d = cnt_addr;
          if (cnt_inc == ilen_q && dlen_q != '0) begin
            cnt_d   = '0;
            state_d = RB_D;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!ren_ext) begin
          // Last read's data is being summed on this edge
          state_d = CHECK;
        end
      end
      RB_D: begin
        if (cnt_q != dlen_q) begin
          ren_d_d  = 1'b1;
          addr_d_d = cnt_addr;
          cnt_d    = cnt_inc;
        end else if (!ren_ext_2 && !ren_ext) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (wsum_q == rsum_q) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      RUN: begin
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_ready_d    = (state_d == LOAD_I) || (state_d == LOAD_D);
    cpu_enable_d = (state_d == RUN);
    error_d      = (state_d == ERR);
    busy_d       = !((state_d == IDLE) || (state_d == RUN) || (state_d == ERR));
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ilen_q      <= '0;
      dlen_q      <= '0;
      wsum_q      <= '0;
      rsum_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      s_ready     <= 1'b0;
      cpu_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ilen_q      <= ilen_d;
      dlen_q      <= dlen_d;
      wsum_q      <= wsum_d;
      rsum_q      <= rsum_d;
      rd_pend_q   <= rd_pend_d;
      rd_sel_q    <= rd_sel_d;
      s_ready     <= s_ready_d;
      cpu_enable  <= cpu_enable_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      wen_ext     <= wen_i_d;
      ren_ext     <= ren_i_d;
      addr_ext    <= addr_i_d;
      wdata_ext   <= wdata_i_d;
      wen_ext_2   <= wen_d_d;
      ren_ext_2   <= ren_d_d;
      addr_ext_2  <= addr_d_d;
      wdata_ext_2 <= wdata_d_d;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed and randomized bench for mem_loader with behavioural memories and
// a transaction-level expectation of writes, readbacks and final status.
module tb_mem_loader;

  localparam int unsigned IW = 512;
  localparam int unsigned DWDS = 1024;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic [9:0]  imem_len = '0;
  logic [10:0] dmem_len = '0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] rdata_ext = '0, rdata_ext_2 = '0;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, busy, done, error;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_loader #(.IMEM_WORDS(IW), .DMEM_WORDS(DWDS)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .stop(stop),
    .imem_len(imem_len), .dmem_len(dmem_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
  );

  // Behavioural memories: one-cycle read latency, optional corruption of 0x33
  logic [31:0] imem [IW];
  logic [31:0] dmem [DWDS];
  logic        corrupt = 1'b0;

  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[10:2]]   <= wdata_ext;
    if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
    if (ren_ext)
      rdata_ext <= (corrupt && imem[addr_ext[10:2]] == 32'h33) ? 32'h34 : imem[addr_ext[10:2]];
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
  end

  // Transaction log of everything the DUT drives to the memories
  logic [31:0] wi_addr[$], wi_data[$], wd_addr[$], wd_data[$], ri_addr[$], rd_addr[$];
  int done_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (wen_ext)   begin wi_addr.push_back(addr_ext);   wi_data.push_back(wdata_ext);   end
    if (wen_ext_2) begin wd_addr.push_back(addr_ext_2); wd_data.push_back(wdata_ext_2); end
    if (ren_ext)   ri_addr.push_back(addr_ext);
    if (ren_ext_2) rd_addr.push_back(addr_ext_2);
    if (done) done_cnt++;
    if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " ctl"}, 32'({s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                            cpu_enable, busy, done, error}), 32'h0);
    chk({tag, " bus"}, addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2, 32'h0);
  endtask

  task automatic stop_if_running(input string tag);
    if (cpu_enable) begin
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      chk({tag, " stop drop"}, 32'(cpu_enable), 32'h0);
    end
  endtask

  task automatic pulse_start(input int il, input int dl);
    @(negedge clk); start = 1'b1; imem_len = 10'(il); dmem_len = 11'(dl);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int gap, input string tag);
    int t;
    repeat (gap) begin @(negedge clk); s_valid = 1'b0; end
    @(negedge clk); s_valid = 1'b1; s_data = w;
    t = 0;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk({tag, " s_ready timeout"}, 32'(s_ready), 32'h1);
  endtask

  // Full load/readback/check; expectations come from the word list alone
  task automatic load_run(input int il, input int dl, input logic [31:0] w[$],
                          input int g[$], input logic exp_ok, input string tag);
    int ib, db, rib, rdb, dnb, t;
    logic [31:0] rsum;
    stop_if_running(tag);
    ib = wi_addr.size(); db = wd_addr.size();
    rib = ri_addr.size(); rdb = rd_addr.size(); dnb = done_cnt;
    pulse_start(il, dl);
    for (int k = 0; k < il + dl; k++) send(w[k], (k < g.size()) ? g[k] : 0, tag);
    @(negedge clk); s_valid = 1'b0;
    t = 0;
    while (!(cpu_enable || error) && t < 3000) begin @(negedge clk); t++; end
    chk({tag, " finished"}, 32'(cpu_enable | error), 32'h1);
    chk({tag, " imem wr count"}, 32'(wi_addr.size() - ib), 32'(il));
    chk({tag, " dmem wr count"}, 32'(wd_addr.size() - db), 32'(dl));
    for (int k = 0; k < il && ib + k < wi_addr.size(); k++) begin
      chk({tag, " imem wr addr"}, wi_addr[ib + k], 32'(4 * k));
      chk({tag, " imem wr data"}, wi_data[ib + k], w[k]);
    end
    for (int k = 0; k < dl && db + k < wd_addr.size(); k++) begin
      chk({tag, " dmem wr addr"}, wd_addr[db + k], 32'(4 * k));
      chk({tag, " dmem wr data"}, wd_data[db + k], w[il + k]);
    end
    chk({tag, " imem rd count"}, 32'(ri_addr.size() - rib), 32'(il));
    chk({tag, " dmem rd count"}, 32'(rd_addr.size() - rdb), 32'(dl));
    rsum = '0;
    for (int k = 0; k < il && rib + k < ri_addr.size(); k++) begin
      chk({tag, " imem rd addr"}, ri_addr[rib + k], 32'(4 * k));
      rsum += imem[ri_addr[rib + k][10:2]];
    end
    for (int k = 0; k < dl && rdb + k < rd_addr.size(); k++) begin
      chk({tag, " dmem rd addr"}, rd_addr[rdb + k], 32'(4 * k));
      rsum += dmem[rd_addr[rdb + k][11:2]];
    end
    begin
      logic [31:0] msum;
      msum = '0;
      foreach (w[k]) if (k < il + dl) msum += w[k];
      chk({tag, " memory sum"}, rsum, msum);
    end
    @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - dnb), 32'(exp_ok));
    chk({tag, " cpu_enable"}, 32'(cpu_enable), 32'(exp_ok));
    chk({tag, " error"}, 32'(error), 32'(!exp_ok));
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " wr/rd overlap"}, 32'(overlap_cnt), 32'h0);
  endtask

  initial begin
    logic [31:0] w[$];
    int g[$];
    int ib, t, il, dl;

    // Reset
    #1 arst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("post reset idle");

    // Back-to-back load and run
    w = '{32'h11, 32'h22, 32'h33, 32'hA, 32'hB};
    g = {};
    load_run(3, 2, w, g, 1'b1, "basic");

    // start in RUN is ignored
    ib = wi_addr.size();
    pulse_start(2, 0);
    repeat (3) @(negedge clk);
    chk("start in run cpu_enable", 32'(cpu_enable), 32'h1);
    chk("start in run no writes", 32'(wi_addr.size() - ib), 32'h0);

    // Stall: s_valid 1,0,0,1
    w = '{32'hCAFE_0001, 32'hCAFE_0002};
    g = '{0, 2};
    load_run(2, 0, w, g, 1'b1, "stall");

    // Corrupted readback
    corrupt = 1'b1;
    w = '{32'h11, 32'h22, 32'h33, 32'hA, 32'hB};
    g = {};
    load_run(3, 2, w, g, 1'b0, "corrupt");
    corrupt = 1'b0;

    // stop outside RUN is ignored
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop in err", 32'(error), 32'h1);

    // Zero lengths
    w = {};
    load_run(0, 0, w, g, 1'b1, "zero");

    // Oversize then recovery
    stop_if_running("oversize");
    ib = wi_addr.size();
    pulse_start(600, 0);
    t = 0;
    while (!error && t < 20) begin @(negedge clk); t++; end
    chk("oversize error", 32'(error), 32'h1);
    chk("oversize cpu_enable", 32'(cpu_enable), 32'h0);
    chk("oversize no writes", 32'(wi_addr.size() - ib), 32'h0);
    w = '{32'h1234_5678};
    load_run(1, 0, w, g, 1'b1, "recover");

    // Reset mid-load after 2 of 4 beats
    stop_if_running("midreset");
    pulse_start(4, 0);
    send(32'hAAAA_0000, 0, "midreset");
    send(32'hAAAA_0001, 0, "midreset");
    @(negedge clk); s_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset released");
    w = {};
    for (int k = 0; k < 5; k++) w.push_back($urandom);
    load_run(4, 1, w, g, 1'b1, "reload");

    // Simultaneous start and stop in RUN: stop wins
    @(negedge clk); start = 1'b1; stop = 1'b1; imem_len = 10'd1; dmem_len = 11'd0;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("start+stop cpu_enable", 32'(cpu_enable), 32'h0);
    chk("start+stop busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("start+stop stays idle", 32'(busy | s_ready | error), 32'h0);

    // Randomized loads
    for (int it = 0; it < 10; it++) begin
      il = $urandom_range(0, 6);
      dl = $urandom_range(0, 6);
      w = {};
      g = {};
      for (int k = 0; k < il + dl; k++) begin
        w.push_back($urandom);
        g.push_back($urandom_range(0, 2));
      end
      load_run(il, dl, w, g, 1'b1, $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
